// File: rtl/rr_arb4x16_pkg.sv
// ============================================================================
// Module      : rr_arb4x16_pkg
// Description : Shared types and constants for the 4-channel half-precision
//               round-robin issue stage and its 4:1 selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb4x16_pkg;
   localparam int CH_W   = 16;
   localparam int NUM_CH = 4;

   typedef logic [CH_W-1:0] half_t;
   typedef logic [1:0]      ch_idx_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } out_state_t;
endpackage

`default_nettype wire

// File: rtl/mux4x16_16.sv
// ============================================================================
// Module      : mux4x16_16
// Description : Purely combinational 4:1 selector for 16-bit half words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import rr_arb4x16_pkg::*;

module mux4x16_16 (
   input  half_t   d0,
   input  half_t   d1,
   input  half_t   d2,
   input  half_t   d3,
   input  ch_idx_t sel,
   output half_t   y
);

   always_comb begin
      y = '0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rr_arb4x16.sv
// ============================================================================
// Module      : rr_arb4x16
// Description : Buffers one result per producer and issues one per cycle,
//               round-robin, into a registered 16-bit valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import rr_arb4x16_pkg::*;

module rr_arb4x16 #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       in_valid,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       sel
);

   generate
      if (WIDTH != 16 || NUM_CH != 4) begin : g_bad_params
         $error("rr_arb4x16 supports only WIDTH=16 and NUM_CH=4");
      end
   endgenerate

   out_state_t r_state;
   out_state_t w_state_nxt;
   half_t      r_hold [4];
   logic [3:0] r_full;
   ch_idx_t    r_last;
   ch_idx_t    r_sel;
   half_t      r_out_data;

   logic       w_advance;
   logic       w_gnt_any;
   ch_idx_t    w_gnt_idx;
   logic [3:0] w_grant;
   logic [3:0] w_fill;
   half_t      w_in_data [4];
   half_t      w_mux_y;

   assign w_in_data[0] = in_data0;
   assign w_in_data[1] = in_data1;
   assign w_in_data[2] = in_data2;
   assign w_in_data[3] = in_data3;

   assign out_valid = (r_state == ST_BUSY);
   assign out_data  = r_out_data;
   assign sel       = r_sel;
   assign w_advance = ~out_valid | out_ready;

   // Walk from farthest to nearest so the nearest full channel after r_last wins.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = r_last;
      for (int k = 4; k >= 1; k--) begin
         if (r_full[r_last + 2'(k)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_last + 2'(k);
         end
      end
      if (!w_advance) begin
         w_gnt_any = 1'b0;
      end
   end

   assign w_grant  = w_gnt_any ? (4'b0001 << w_gnt_idx) : 4'b0000;
   assign in_ready = ~r_full | w_grant;
   assign w_fill   = in_valid & in_ready;

   mux4x16_16 u_mux (
      .d0  (r_hold[0]),
      .d1  (r_hold[1]),
      .d2  (r_hold[2]),
      .d3  (r_hold[3]),
      .sel (w_gnt_idx),
      .y   (w_mux_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_advance) begin
         w_state_nxt = w_gnt_any ? ST_BUSY : ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data <= '0;
         r_sel      <= 2'b00;
         r_last     <= 2'b11;
      end else if (w_gnt_any) begin
         r_out_data <= w_mux_y;
         r_sel      <= w_gnt_idx;
         r_last     <= w_gnt_idx;
      end
   end

   // A fill in the same cycle as a drain keeps the slot occupied.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_ch
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_hold[i] <= '0;
               r_full[i] <= 1'b0;
            end else if (w_fill[i]) begin
               r_hold[i] <= w_in_data[i];
               r_full[i] <= 1'b1;
            end else if (w_grant[i]) begin
               r_full[i] <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4x16.sv
// ============================================================================
// Module      : tb_rr_arb4x16
// Description : Self-checking bench for rr_arb4x16 with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb4x16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  in_valid = 4'b0000;
   logic [15:0] d [4];
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready = 1'b1;
   logic [1:0]  sel;

   int ncmp = 0;
   int nfail = 0;

   // model state
   bit          m_full [4];
   logic [15:0] m_hold [4];
   int          m_last;
   bit          m_ov;
   logic [15:0] m_od;
   int          m_sel;

   always #5 clk = ~clk;

   rr_arb4x16 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data0  (d[0]),
      .in_data1  (d[1]),
      .in_data2  (d[2]),
      .in_data3  (d[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 4; i++) begin
         m_full[i] = 1'b0;
         m_hold[i] = 16'h0000;
      end
      m_last = 3;
      m_ov   = 1'b0;
      m_od   = 16'h0000;
      m_sel  = 0;
   endtask

   function automatic int m_grant();
      if (m_ov && !out_ready) return -1;
      for (int k = 1; k <= 4; k++) begin
         if (m_full[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return -1;
   endfunction

   // One clock with the currently driven inputs; checks ready before and outputs after.
   task automatic tick();
      int         g;
      logic [3:0] er;
      #1;
      g = m_grant();
      for (int i = 0; i < 4; i++) er[i] = !m_full[i] || (g == i);
      check("in_ready", {28'd0, in_ready}, {28'd0, er});
      if (g >= 0) begin
         m_od = m_hold[g]; m_sel = g; m_ov = 1'b1; m_last = g; m_full[g] = 1'b0;
      end else if (!m_ov || out_ready) begin
         m_ov = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (in_valid[i] && er[i]) begin
            m_hold[i] = d[i];
            m_full[i] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      check("out_data", {16'd0, out_data}, {16'd0, m_od});
      check("sel", {30'd0, sel}, m_sel);
   endtask

   task automatic do_reset();
      in_valid = 4'b0000;
      #3 reset = 1'b1;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sel", {30'd0, sel}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_in_ready", {28'd0, in_ready}, 32'hF);
      m_reset();
      @(posedge clk);
      #3 reset = 1'b0;
   endtask

   initial begin
      int          c0, c3, prev;
      logic [15:0] v [4];
      for (int i = 0; i < 4; i++) d[i] = 16'h0000;
      m_reset();
      do_reset();

      // single channel latency
      d[2] = 16'h3C00; in_valid = 4'b0100; out_ready = 1'b1;
      tick();
      in_valid = 4'b0000;
      tick();
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_data", {16'd0, out_data}, 32'h3C00);
      check("t1_sel", {30'd0, sel}, 32'd2);
      tick();
      check("t1_idle", {31'd0, out_valid}, 32'd0);

      // all four full, round-robin order from channel 0
      do_reset();
      v[0] = 16'h3C00; v[1] = 16'h4000; v[2] = 16'hC000; v[3] = 16'h7C00;
      for (int i = 0; i < 4; i++) d[i] = v[i];
      in_valid = 4'b1111;
      tick();
      in_valid = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t2_sel", {30'd0, sel}, k);
         check("t2_data", {16'd0, out_data}, {16'd0, v[k]});
      end
      tick();
      check("t2_idle", {31'd0, out_valid}, 32'd0);

      // backpressure
      d[1] = 16'h4000; d[2] = 16'hC000; d[3] = 16'h7C00;
      in_valid = 4'b1110;
      tick();
      in_valid = 4'b0000;
      tick();
      check("t3_sel", {30'd0, sel}, 32'd1);
      out_ready = 1'b0;
      d[2] = 16'h1234; in_valid = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_hold_data", {16'd0, out_data}, 32'h4000);
         check("t3_hold_sel", {30'd0, sel}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check("t3_next_sel", {30'd0, sel}, 32'd2);
      check("t3_next_data", {16'd0, out_data}, 32'hC000);
      in_valid = 4'b0000;
      repeat (4) tick();

      // same-cycle drain and refill on channel 0
      in_valid = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         d[0] = (k % 2) ? 16'h0002 : 16'h0001;
         tick();
         check("t4_ready0", {31'd0, in_ready[0]}, 32'd1);
         if (k >= 1) begin
            check("t4_valid", {31'd0, out_valid}, 32'd1);
            check("t4_data", {16'd0, out_data}, ((k - 1) % 2) ? 32'h2 : 32'h1);
         end
      end
      in_valid = 4'b0000;
      repeat (2) tick();

      // fairness between channels 0 and 3
      c0 = 0; c3 = 0; prev = -1;
      in_valid = 4'b1001;
      for (int k = 0; k < 20; k++) begin
         d[0] = 16'($urandom); d[3] = 16'($urandom);
         tick();
         if (out_valid) begin
            if (sel == 2'd0) c0++;
            if (sel == 2'd3) c3++;
            if (prev >= 0) check("t5_alt", {31'd0, (int'(sel) != prev)}, 32'd1);
            prev = int'(sel);
         end
      end
      check("t5_cnt0", {31'd0, (c0 >= 9 && c0 <= 11)}, 32'd1);
      check("t5_cnt3", {31'd0, (c3 >= 9 && c3 <= 11)}, 32'd1);
      in_valid = 4'b0000;
      repeat (3) tick();

      // async reset mid-stream
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      in_valid = 4'b1111;
      tick();
      in_valid = 4'b0000;
      tick();
      check("t6_busy", {31'd0, out_valid}, 32'd1);
      do_reset();
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      in_valid = 4'b1111;
      tick();
      in_valid = 4'b0000;
      tick();
      check("t6_first_sel", {30'd0, sel}, 32'd0);
      check("t6_first_data", {16'd0, out_data}, {16'd0, d[0]});

      // randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_arb4x16.md
Name: rr_arb4x16

Overview:
- Upstream issue stage for the 4:1 16-bit selector in the half-precision datapath.
- Four producers (e.g. add, mul, convert, load units) each present a 16-bit result with a valid/ready handshake.
- The block buffers one result per producer and picks one per cycle round-robin. It drives the 2-bit select plus a registered 16-bit result to the consumer with valid/ready.
- It owns the selector's sel and instantiates the selector internally.

Parameters:
- WIDTH, 16, data width of each channel and of out_data; only 16 is supported by the selector.
- NUM_CH, 4, number of channels; fixed at 4, elaboration error otherwise.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  4  per-channel valid, bit i = channel i
- in_data0..in_data3  in  16 each  channel data
- in_ready  out  4  per-channel ready
- out_valid  out  1  out_data holds an unconsumed result
- out_data  out  16  selected result, registered
- out_ready  in  1  consumer accepts when out_valid & out_ready
- sel  out  2  channel index of the current out_data, registered

Behaviour:
- State:
  - hold[i] (16b) and full[i] (1b) per channel.
  - last (2b): index of the last granted channel.
  - Output register: out_valid, out_data, sel.
- Reset values: full=0, hold=0, out_valid=0, out_data=16'h0000, sel=2'b00, last=2'b11, so channel 0 has first priority.
- Output state machine:
  - IDLE (out_valid=0).
  - BUSY (out_valid=1).
- advance = ~out_valid | out_ready (output register free or being drained this cycle).
- Grant:
  - Combinational.
  - Search full[] starting at last+1, wrapping mod 4; the first full channel wins.
  - If advance=0 or no channel is full, there is no grant.
- On grant g at a clock edge:
  - out_data <= hold[g], sel <= g, out_valid <= 1, last <= g, full[g] <= 0 (unless refilled the same cycle, see below).
- On advance with no grant: out_valid <= 0. out_data and sel keep their old values.
- BUSY with out_ready=0: out_valid, out_data and sel are held stable, with no change permitted.
- in_ready[i] = ~full[i] | grant[i].
  - A channel drained this cycle may be refilled the same cycle; the fill wins and full[i] stays 1.
  - in_ready depends combinationally on out_ready.
- Capture: when in_valid[i] & in_ready[i], hold[i] <= in_data_i and full[i] <= 1.
- Latency: data accepted at edge N appears with out_valid=1 after edge N+1, when the output is free. Minimum latency is 2 cycles, with no combinational input-to-output path.
- Throughput: one result per cycle when out_ready=1 and any channel is full. Each channel sustains one per cycle if it is alone.
- Fairness: with all four channels continuously full, grants go 0,1,2,3,0,... and no channel waits more than 4 grants.
- in_valid on a full, ungranted channel: the producer must hold its data; it is not captured and nothing is dropped.
- Reset mid-operation: all buffered and in-flight results are discarded and in_ready returns to 4'b1111 combinationally.
- Data is treated as opaque bits; no float interpretation (NaN/Inf pass unchanged).

Decomposition:
- Shared package:
  - CH_W=16 and NUM_CH=4 constants.
  - typedef half_t (logic [15:0]).
  - typedef ch_idx_t (logic [1:0]).
- One sub-module: the existing 4:1 16-bit selector (mux4x16_16), fed with hold[0..3] and the combinational grant index. Its output loads out_data.
- Round-robin search stays inline in this block.

Test Plan:
- Reset, then single channel: in_data2=16'h3C00 valid for 1 cycle at edge N, out_ready=1 -> out_valid=1 after edge N+1, out_data=16'h3C00, sel=2'b10; out_valid=0 one cycle later.
- All four channels full with 16'h3C00/16'h4000/16'hC000/16'h7C00, out_ready=1 -> four consecutive outputs in order sel=0,1,2,3 with matching data; then out_valid=0.
- Backpressure: out_ready=0 for 5 cycles while BUSY with 16'h4000, sel=1 -> out_data and sel unchanged throughout. The other full channels keep in_ready=0 and nothing is lost. On release, the next grant is channel 2.
- Same-cycle drain and refill on channel 0 with alternating 16'h0001/16'h0002 every cycle, out_ready=1 -> in_ready[0] stays 1 and outputs arrive back-to-back, one per cycle, in order.
- Fairness: channels 0 and 3 continuously valid for 20 cycles -> grants alternate 0,3,0,3,... and each gets 10 (±1).
- Async reset asserted mid-stream between clock edges with 3 channels full and out_valid=1 -> out_valid, full and sel go 0 immediately, and in_ready=4'b1111. After release, the first grant is channel 0 when all channels are valid.
